writeback_queue: RTL
====================

// Module: writeback_queue
// PURPOSE
//  Parametrised writeback stage for the pipeline: accepts retired memory-stage results over a valid/ready handshake.
//  Formats load data (byte/half/word/double, signed/unsigned, address-aligned) and selects ALU vs load result.
//  Buffers results in a DEPTH-entry in-order FIFO; drains one entry per cycle to the register-file port and commit
//  interface when the port grants (wb_ready). Provides youngest-match forwarding of pending writes to decode.
// PARAMETERS
//  XLEN        64  datapath width; power of two, >= 32
//  DEPTH       4   FIFO entries; power of two, >= 2
//  REG_ADDR_W  5   register index width
// PORTS
//  clk          in   1           clock, all state on rising edge
//  reset        in   1           asynchronous, active-low (0 = reset)
//  in_valid     in   1           memory stage presents a result
//  in_ready     out  1           queue accepts this cycle
//  in_pc        in   XLEN        instruction PC
//  in_raw_instr in   32          raw instruction
//  in_skip      in   1           difftest skip flag, passed through
//  in_dst       in   REG_ADDR_W  destination register
//  in_regwrite  in   1           instruction writes a register
//  in_memtoreg  in   1           1 = load result, 0 = ALU result
//  in_aluout    in   XLEN        ALU result
//  in_readdata  in   XLEN        raw aligned memory word
//  in_msize     in   2           0=byte 1=half 2=word 3=dword
//  in_msigned   in   1           sign-extend load
//  in_addr_lo   in   log2(XLEN/8) byte offset of load address
//  wb_ready     in   1           register-file port granted this cycle
//  rf_wen       out  1           register write strobe
//  rf_waddr     out  REG_ADDR_W  write index
//  rf_wdata     out  XLEN        write data
//  commit_valid out  1           one instruction retires this cycle
//  commit_pc    out  XLEN        retiring PC
//  commit_instr out  32          retiring raw instruction
//  commit_skip  out  1           retiring skip flag
//  count        out  log2(DEPTH)+1  occupied entries
//  fwd_addr     in   REG_ADDR_W  forwarding query index
//  fwd_hit      out  1           pending write to fwd_addr exists
//  fwd_data     out  XLEN        data of youngest matching entry
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): rd/wr pointers=0, count=0, entry valid bits cleared; every output 0
//    except in_ready=1. Reset mid-operation discards all entries; nothing commits on the next cycle.
//  - Enqueue when in_valid && in_ready; in_ready = (count < DEPTH). No pass-through when full: a simultaneous
//    dequeue on a full queue frees a slot only for the next cycle.
//  - Formatting at enqueue (combinational, stored): memtoreg=1 -> sh = readdata >> (addr_lo*8); take low 8/16/32/64
//    bits per msize; sign-extend if msigned else zero-extend to XLEN. memtoreg=0 -> aluout. msize=3 ignores msigned.
//  - Stored per entry: pc, instr, skip, dst, wen = regwrite && (dst != 0), wdata.
//  - Head drains when count>0 && wb_ready: commit_valid=1 with head fields; rf_wen=head.wen; rf_waddr/rf_wdata=head.
//    Outputs are combinational from head and wb_ready; all other cycles commit_valid=rf_wen=0, data fields hold head.
//  - Latency: entry enqueued in cycle N is earliest at head/commit in cycle N+1.
//  - Simultaneous enqueue+dequeue: count unchanged, both pointers advance; pointers wrap modulo DEPTH.
//  - count: +1 on enqueue only, -1 on dequeue only; range 0..DEPTH, never over/underflows.
//  - Forwarding: fwd_hit=1 if any occupied entry has wen && dst==fwd_addr; fwd_data from youngest such entry
//    (closest to wr pointer). fwd_addr=0 -> fwd_hit=0, fwd_data=0. Entry draining this cycle still counts as hit.
//    Input-port value not yet enqueued is not forwarded.
//  - In-order: commit order equals enqueue order; no entry dropped or duplicated.
// TESTING
//  1 Reset low mid-stream with count=3 -> count=0, commit_valid=0, in_ready=1 next cycle; no stale commit.
//  2 Load readdata=0x0000_0000_0000_8000, addr_lo=1, msize=0, msigned=1 -> rf_wdata=0xFFFF_FFFF_FFFF_FF80;
//    same with msigned=0 -> 0x0000_0000_0000_0080.
//  3 wb_ready=0, 5 back-to-back in_valid -> 4 accepted, in_ready=0 at count=4; raise wb_ready -> commits PC order.
//  4 Full queue, in_valid && wb_ready same cycle -> 1 commit, no enqueue, count=3; next cycle enqueue, count=3 again.
//  5 Entries dst=x5 data 0x11 then x5 data 0x22, fwd_addr=5 -> fwd_hit=1, fwd_data=0x22; dst=x0 entry -> rf_wen=0,
//    commit_valid=1, fwd_addr=0 -> fwd_hit=0.
//  6 Random valid/wb_ready 10k cycles vs scoreboard model -> commit stream and rf writes match exactly.

Source files
------------

// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue
//
// Writeback stage for the pipeline. Retired memory-stage results arrive over a
// valid/ready handshake. Load data is aligned and extended on entry, and the
// stored result is either that load value or the ALU result. Results wait in a
// DEPTH-entry in-order FIFO. The head drains one entry per cycle to the
// register-file write port and the commit interface whenever the port is
// granted. Decode can query pending register writes through a forwarding port.
//
// Ports
//   clk_i           clock; all state updates on the rising edge
//   rst_ni          asynchronous reset, active low
//   in_valid_i      memory stage presents a result
//   in_ready_o      queue accepts a result this cycle (not full)
//   in_pc_i         instruction PC
//   in_raw_instr_i  raw 32-bit instruction
//   in_skip_i       difftest skip flag, carried to commit
//   in_dst_i        destination register index
//   in_regwrite_i   instruction writes a register
//   in_memtoreg_i   1 = load result, 0 = ALU result
//   in_aluout_i     ALU result
//   in_readdata_i   raw aligned memory word
//   in_msize_i      load size: 0 byte, 1 half, 2 word, 3 double
//   in_msigned_i    sign-extend the load value
//   in_addr_lo_i    byte offset of the load address within the word
//   wb_ready_i      register-file port granted this cycle
//   rf_wen_o        register write strobe
//   rf_waddr_o      register write index
//   rf_wdata_o      register write data
//   commit_valid_o  one instruction retires this cycle
//   commit_pc_o     retiring PC
//   commit_instr_o  retiring raw instruction
//   commit_skip_o   retiring skip flag
//   count_o         number of occupied entries (0..DEPTH)
//   fwd_addr_i      forwarding query register index
//   fwd_hit_o       a pending write to fwd_addr_i exists
//   fwd_data_o      data of the youngest matching pending write
// ---------------------------------------------------------------------------
module writeback_queue #(
   parameter int XLEN       = 64,
   parameter int DEPTH      = 4,
   parameter int REG_ADDR_W = 5
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,

   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [XLEN-1:0]            in_pc_i,
   input  logic [31:0]                in_raw_instr_i,
   input  logic                       in_skip_i,
   input  logic [REG_ADDR_W-1:0]      in_dst_i,
   input  logic                       in_regwrite_i,
   input  logic                       in_memtoreg_i,
   input  logic [XLEN-1:0]            in_aluout_i,
   input  logic [XLEN-1:0]            in_readdata_i,
   input  logic [1:0]                 in_msize_i,
   input  logic                       in_msigned_i,
   input  logic [$clog2(XLEN/8)-1:0]  in_addr_lo_i,

   input  logic                       wb_ready_i,
   output logic                       rf_wen_o,
   output logic [REG_ADDR_W-1:0]      rf_waddr_o,
   output logic [XLEN-1:0]            rf_wdata_o,

   output logic                       commit_valid_o,
   output logic [XLEN-1:0]            commit_pc_o,
   output logic [31:0]                commit_instr_o,
   output logic                       commit_skip_o,

   output logic [$clog2(DEPTH):0]     count_o,

   input  logic [REG_ADDR_W-1:0]      fwd_addr_i,
   output logic                       fwd_hit_o,
   output logic [XLEN-1:0]            fwd_data_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   // Entry storage, indexed by pointer
   logic [XLEN-1:0]       pc_q    [DEPTH];
   logic [31:0]           instr_q [DEPTH];
   logic                  skip_q  [DEPTH];
   logic [REG_ADDR_W-1:0] dst_q   [DEPTH];
   logic                  wen_q   [DEPTH];
   logic [XLEN-1:0]       wdata_q [DEPTH];
   logic [DEPTH-1:0]      valid_q;
   logic [DEPTH-1:0]      valid_d;

   logic [PTR_W-1:0]      rd_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      wr_ptr_d;
   logic [CNT_W-1:0]      count_q;
   logic [CNT_W-1:0]      count_d;

   logic                  enq;
   logic                  deq;

   logic [XLEN-1:0]       load_shifted;
   logic [XLEN-1:0]       load_fmt;
   logic                  sign_bit;
   int                    keep_bits;
   logic [XLEN-1:0]       enq_wdata;
   logic                  enq_wen;
   logic [PTR_W-1:0]      fwd_idx;

   // Handshake. Readiness depends only on registered occupancy, so a dequeue
   // in the same cycle does not open a slot until the following cycle.
   assign in_ready_o = (count_q < DEPTH_CNT);
   assign enq        = in_valid_i && in_ready_o;
   assign deq        = (count_q != '0) && wb_ready_i;

   // Align the load word so the addressed byte lands at bit 0.
   assign load_shifted = in_readdata_i >> {in_addr_lo_i, 3'b000};

   // Keep the low 8/16/32/64 bits of the aligned word and fill the rest with
   // either zeros or the top kept bit. A double never sign-extends, and on a
   // 32-bit datapath it simply keeps the whole word.
   always_comb begin
      sign_bit  = 1'b0;
      keep_bits = 64;
      unique case (in_msize_i)
         2'd0: begin
            keep_bits = 8;
            sign_bit  = load_shifted[7];
         end
         2'd1: begin
            keep_bits = 16;
            sign_bit  = load_shifted[15];
         end
         2'd2: begin
            keep_bits = 32;
            sign_bit  = load_shifted[31];
         end
         default: begin
            keep_bits = 64;
            sign_bit  = 1'b0;
         end
      endcase
      load_fmt = '0;
      for (int b = 0; b < XLEN; b++) begin
         load_fmt[b] = (b < keep_bits) ? load_shifted[b] : (in_msigned_i & sign_bit);
      end
   end

   // Writes to x0 are never performed, so the strobe is cleared at entry.
   assign enq_wdata = in_memtoreg_i ? load_fmt : in_aluout_i;
   assign enq_wen   = in_regwrite_i && (in_dst_i != '0);

   // Pointer, occupancy and valid-bit next state. Enqueue and dequeue can never
   // touch the same slot: that would need the queue to be both empty and full.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;
      if (deq) begin
         rd_ptr_d          = rd_ptr_q + 1'b1;
         valid_d[rd_ptr_q] = 1'b0;
      end
      if (enq) begin
         wr_ptr_d          = wr_ptr_q + 1'b1;
         valid_d[wr_ptr_q] = 1'b1;
      end
      unique case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // State registers. Entry contents are cleared on reset as well, so the head
   // data outputs read zero until the first real entry arrives.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_q[i]    <= '0;
            instr_q[i] <= '0;
            skip_q[i]  <= 1'b0;
            dst_q[i]   <= '0;
            wen_q[i]   <= 1'b0;
            wdata_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
         if (enq) begin
            pc_q[wr_ptr_q]    <= in_pc_i;
            instr_q[wr_ptr_q] <= in_raw_instr_i;
            skip_q[wr_ptr_q]  <= in_skip_i;
            dst_q[wr_ptr_q]   <= in_dst_i;
            wen_q[wr_ptr_q]   <= enq_wen;
            wdata_q[wr_ptr_q] <= enq_wdata;
         end
      end
   end

   // Head presentation. Data fields always show the head; the strobes only
   // fire in a cycle where the head actually drains.
   assign commit_valid_o = deq;
   assign commit_pc_o    = pc_q[rd_ptr_q];
   assign commit_instr_o = instr_q[rd_ptr_q];
   assign commit_skip_o  = skip_q[rd_ptr_q];
   assign rf_wen_o       = deq && wen_q[rd_ptr_q];
   assign rf_waddr_o     = dst_q[rd_ptr_q];
   assign rf_wdata_o     = wdata_q[rd_ptr_q];
   assign count_o        = count_q;

   // Forwarding walks occupied entries from oldest to youngest so the last
   // match seen is the youngest one. The head still counts while draining.
   always_comb begin
      fwd_hit_o  = 1'b0;
      fwd_data_o = '0;
      fwd_idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && valid_q[fwd_idx] && wen_q[fwd_idx] &&
             (dst_q[fwd_idx] == fwd_addr_i) && (fwd_addr_i != '0)) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = wdata_q[fwd_idx];
         end
      end
   end

   // Occupancy bookkeeping must stay consistent between the counter and the
   // per-entry valid bits.
   countInRange: assert property (@(posedge clk_i) disable iff (!rst_ni)
      count_q <= DEPTH_CNT);
   validMatchesCount: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $countones(valid_q) == 32'(count_q));

endmodule
